// File: rtl/llm_pkg.sv
// Shared lamp-interface encodings for the light sequencer and the lamp monitor.
// State codes double as the external `phase` value.
package llm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    RED    = 3'd3,
    DARK   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_SKIP    = 2'd1,
    FAULT_STRETCH = 2'd2,
    FAULT_DARK    = 2'd3
  } fault_e;

endpackage

// File: rtl/phase_timer.sv
// Per-phase elapsed-cycle counter with a terminal flag at length-1.
// count_next is exposed so the owner can register outputs aligned with the counter.
module phase_timer #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] length,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         last
);

  logic [W-1:0] count_q;

  always_comb begin
    count_next = clear ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_next;
  end

  assign count = count_q;
  assign last  = (count_q == length - 1'b1);

endmodule

// File: rtl/light_sequencer.sv
// Green/yellow/red lamp sequencer with one-shot fault injection per light cycle.
// FSM, fault latches and all lamp-side outputs are registered here.
module light_sequencer
  import llm_pkg::*;
#(
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 3,
  parameter int RED_TIME    = 20,
  parameter int TIMER_W     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         fault_sel,
  input  logic               fault_arm,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic [2:0]         phase,
  output logic [TIMER_W-1:0] timer,
  output logic               cycle_done,
  output logic               fault_active
);

  localparam logic [TIMER_W-1:0] LEN_G  = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] LEN_Y  = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] LEN_Y2 = TIMER_W'(2 * YELLOW_TIME);
  localparam logic [TIMER_W-1:0] LEN_R  = TIMER_W'(RED_TIME);

  state_e state_q, state_d;
  fault_e fault_pending_q, fault_pending_d;
  fault_e fault_cur_q, fault_cur_d;
  logic green_q, green_d, yellow_q, yellow_d, red_q, red_d;
  logic [2:0] phase_q, phase_d;
  logic cycle_done_q, cycle_done_d, fault_active_q, fault_active_d;

  logic [TIMER_W-1:0] length, count_next;
  logic               last, clear, green_entry;

  always_comb begin
    unique case (state_q)
      GREEN:   length = LEN_G;
      YELLOW:  length = (fault_cur_q == FAULT_STRETCH) ? LEN_Y2 : LEN_Y;
      RED:     length = LEN_R;
      DARK:    length = LEN_Y;
      default: length = TIMER_W'(1);
    endcase
  end

  // Every phase ends on its last count, so clearing there restarts the timer at 0.
  assign clear = (state_q == IDLE) || last;

  phase_timer #(.W(TIMER_W)) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .length     (length),
    .count      (timer),
    .count_next (count_next),
    .last       (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (enable) state_d = GREEN;
      GREEN:  if (last) begin
                if (fault_cur_q == FAULT_SKIP)      state_d = RED;
                else if (fault_cur_q == FAULT_DARK) state_d = DARK;
                else                                state_d = YELLOW;
              end
      YELLOW: if (last) state_d = RED;
      DARK:   if (last) state_d = RED;
      RED:    if (last) state_d = enable ? GREEN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An arm coinciding with GREEN entry survives in pending for the following cycle.
  always_comb begin
    green_entry     = (state_d == GREEN) && (state_q != GREEN);
    fault_pending_d = fault_pending_q;
    if (green_entry) fault_pending_d = FAULT_NONE;
    if (fault_arm && (fault_sel != 2'd0)) fault_pending_d = fault_e'(fault_sel);

    fault_cur_d = fault_cur_q;
    if ((state_q == RED) && last) fault_cur_d = FAULT_NONE;
    if (green_entry) fault_cur_d = fault_pending_q;
  end

  always_comb begin
    green_d        = (state_d == GREEN);
    yellow_d       = (state_d == YELLOW);
    red_d          = (state_d == RED);
    phase_d        = state_d;
    cycle_done_d   = (state_d == RED) && (count_next == LEN_R - 1'b1);
    fault_active_d = (state_d != IDLE) && (fault_cur_d != FAULT_NONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      fault_pending_q <= FAULT_NONE;
      fault_cur_q     <= FAULT_NONE;
      green_q         <= 1'b0;
      yellow_q        <= 1'b0;
      red_q           <= 1'b0;
      phase_q         <= 3'd0;
      cycle_done_q    <= 1'b0;
      fault_active_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      fault_pending_q <= fault_pending_d;
      fault_cur_q     <= fault_cur_d;
      green_q         <= green_d;
      yellow_q        <= yellow_d;
      red_q           <= red_d;
      phase_q         <= phase_d;
      cycle_done_q    <= cycle_done_d;
      fault_active_q  <= fault_active_d;
    end
  end

  assign green        = green_q;
  assign yellow       = yellow_q;
  assign red          = red_q;
  assign phase        = phase_q;
  assign cycle_done   = cycle_done_q;
  assign fault_active = fault_active_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: directed test-plan scenarios plus a randomized run
// checked against a cycle-position reference model.
module tb_light_sequencer;

  localparam int GT = 25;
  localparam int YT = 3;
  localparam int RT = 20;
  localparam int TW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    fault_sel = 2'd0;
  logic          fault_arm = 1'b0;
  logic          green, yellow, red, cycle_done, fault_active;
  logic [2:0]    phase;
  logic [TW-1:0] timer;

  int total = 0;
  int bad = 0;

  light_sequencer #(
    .GREEN_TIME(GT), .YELLOW_TIME(YT), .RED_TIME(RT), .TIMER_W(TW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .fault_sel(fault_sel),
    .fault_arm(fault_arm), .green(green), .yellow(yellow), .red(red),
    .phase(phase), .timer(timer), .cycle_done(cycle_done), .fault_active(fault_active)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic g, y, r;
    logic [2:0] ph;
    logic [TW-1:0] tm;
    logic cd, fa;
  } samp_t;

  samp_t cap[200];

  function automatic samp_t dut_now();
    return {green, yellow, red, phase, timer, cycle_done, fault_active};
  endfunction

  // Reference: a light cycle is a flat list of positions 0..len-1; the phase is
  // found by comparing the position against cumulative phase boundaries.
  function automatic int mid_len(input int f);
    return (f == 1) ? 0 : (f == 2) ? 2 * YT : YT;
  endfunction

  function automatic int cycle_len(input int f);
    return GT + mid_len(f) + RT;
  endfunction

  function automatic samp_t model_out(input bit run, input int pos, input int f);
    samp_t s = '0;
    if (!run) return s;
    if (pos < GT) begin
      s.g = 1'b1; s.ph = 3'd1; s.tm = TW'(pos);
    end else if (pos < GT + mid_len(f)) begin
      s.ph = (f == 3) ? 3'd4 : 3'd2; s.y = (f != 3); s.tm = TW'(pos - GT);
    end else begin
      s.r = 1'b1; s.ph = 3'd3; s.tm = TW'(pos - GT - mid_len(f));
    end
    s.cd = (pos == cycle_len(f) - 1);
    s.fa = (f != 0);
    return s;
  endfunction

  bit m_run = 1'b0;
  int m_pos = 0;
  int m_fcur = 0;
  int m_pend = 0;

  always @(posedge clock) begin
    bit at_end, start;
    int new_pend;
    at_end   = m_run && (m_pos == cycle_len(m_fcur) - 1);
    start    = m_run ? (at_end && enable) : enable;
    new_pend = (fault_arm && fault_sel != 2'd0) ? int'(fault_sel) : (start ? 0 : m_pend);
    if (reset) begin
      m_run = 1'b0; m_pos = 0; m_fcur = 0; m_pend = 0;
    end else begin
      if (start) begin
        m_fcur = m_pend; m_run = 1'b1; m_pos = 0;
      end else if (at_end) begin
        m_fcur = 0; m_run = 1'b0; m_pos = 0;
      end else if (m_run) begin
        m_pos = m_pos + 1;
      end
      m_pend = new_pend;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; fault_arm = 1'b0; fault_sel = 2'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cap[i] = dut_now();
    end
  endtask

  // what: 0 green, 1 yellow, 2 red, 3 dark, 4 fault_active, 5 lamp overlap
  function automatic int cnt(input int lo, input int hi, input int what);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (what)
        0: n += int'(cap[i].g);
        1: n += int'(cap[i].y);
        2: n += int'(cap[i].r);
        3: n += int'(cap[i].ph == 3'd4 && !cap[i].g && !cap[i].y && !cap[i].r);
        4: n += int'(cap[i].fa);
        default: n += int'((int'(cap[i].g) + int'(cap[i].y) + int'(cap[i].r)) > 1);
      endcase
    end
    return n;
  endfunction

  function automatic int first_done(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (cap[i].cd) return i;
    return -1;
  endfunction

  task automatic arm_in_idle(input logic [1:0] sel);
    fault_sel = sel; fault_arm = 1'b1;
    @(negedge clock);
    fault_arm = 1'b0; fault_sel = 2'd0;
  endtask

  task automatic test_reset();
    int v;
    do_reset();
    total++; if (dut_now() !== samp_t'(0)) begin bad++; $display("FAIL reset_state: got %h want 0", dut_now()); end
    @(negedge clock);
    total++; if (dut_now() !== samp_t'(0)) begin bad++; $display("FAIL idle_hold: got %h want 0", dut_now()); end
    v = 0;
  endtask

  task automatic test_normal();
    do_reset();
    enable = 1'b1;
    capture(49);
    total++; if (cap[0].g !== 1'b1) begin bad++; $display("FAIL enable_latency: green=%b want 1", cap[0].g); end
    total++; if (cnt(0, 47, 0) != GT) begin bad++; $display("FAIL normal_green: got %0d want %0d", cnt(0, 47, 0), GT); end
    total++; if (cnt(0, 47, 1) != YT) begin bad++; $display("FAIL normal_yellow: got %0d want %0d", cnt(0, 47, 1), YT); end
    total++; if (cnt(0, 47, 2) != RT) begin bad++; $display("FAIL normal_red: got %0d want %0d", cnt(0, 47, 2), RT); end
    total++; if (first_done(0, 48) != GT + YT + RT - 1) begin bad++; $display("FAIL normal_done_at: got %0d want %0d", first_done(0, 48), GT + YT + RT - 1); end
    total++; if (cap[47].tm !== TW'(RT - 1)) begin bad++; $display("FAIL red_last_timer: got %0d want %0d", cap[47].tm, RT - 1); end
    total++; if (cap[48].g !== 1'b1 || cap[48].tm !== '0) begin bad++; $display("FAIL green_return: got g=%b t=%0d want g=1 t=0", cap[48].g, cap[48].tm); end
    total++; if (cnt(0, 48, 5) != 0) begin bad++; $display("FAIL normal_overlap: got %0d want 0", cnt(0, 48, 5)); end
    total++; if (cnt(0, 48, 4) != 0) begin bad++; $display("FAIL normal_fault_active: got %0d want 0", cnt(0, 48, 4)); end
  endtask

  task automatic test_fault_skip();
    do_reset();
    arm_in_idle(2'd1);
    enable = 1'b1;
    capture(94);
    total++; if (cnt(0, 44, 1) != 0) begin bad++; $display("FAIL skip_yellow: got %0d want 0", cnt(0, 44, 1)); end
    total++; if (cnt(0, 44, 0) != GT || cnt(0, 44, 2) != RT) begin bad++; $display("FAIL skip_gr: got g=%0d r=%0d want %0d %0d", cnt(0, 44, 0), cnt(0, 44, 2), GT, RT); end
    total++; if (first_done(0, 93) != GT + RT - 1) begin bad++; $display("FAIL skip_done_at: got %0d want %0d", first_done(0, 93), GT + RT - 1); end
    total++; if (cnt(0, 44, 4) != GT + RT) begin bad++; $display("FAIL skip_active: got %0d want %0d", cnt(0, 44, 4), GT + RT); end
    total++; if (cnt(45, 92, 4) != 0 || cnt(45, 92, 1) != YT) begin bad++; $display("FAIL skip_next_normal: got fa=%0d y=%0d want 0 %0d", cnt(45, 92, 4), cnt(45, 92, 1), YT); end
    total++; if (first_done(45, 93) != 92) begin bad++; $display("FAIL skip_next_done: got %0d want 92", first_done(45, 93)); end
  endtask

  task automatic test_fault_stretch();
    int tmax = 0;
    do_reset();
    arm_in_idle(2'd2);
    enable = 1'b1;
    capture(51);
    for (int i = 0; i < 51; i++) if (cap[i].ph == 3'd2 && int'(cap[i].tm) > tmax) tmax = int'(cap[i].tm);
    total++; if (cnt(0, 50, 1) != 2 * YT) begin bad++; $display("FAIL stretch_yellow: got %0d want %0d", cnt(0, 50, 1), 2 * YT); end
    total++; if (tmax != 2 * YT - 1) begin bad++; $display("FAIL stretch_timer: got %0d want %0d", tmax, 2 * YT - 1); end
    total++; if (first_done(0, 50) != 50 || cnt(0, 50, 4) != 51) begin bad++; $display("FAIL stretch_cycle: got done=%0d fa=%0d want 50 51", first_done(0, 50), cnt(0, 50, 4)); end
  endtask

  task automatic test_fault_dark();
    do_reset();
    arm_in_idle(2'd3);
    enable = 1'b1;
    capture(48);
    total++; if (cnt(0, 47, 3) != YT || cnt(0, 47, 1) != 0) begin bad++; $display("FAIL dark_lamps: got dark=%0d y=%0d want %0d 0", cnt(0, 47, 3), cnt(0, 47, 1), YT); end
    total++; if (cap[GT].ph !== 3'd4 || cap[GT + YT].r !== 1'b1) begin bad++; $display("FAIL dark_order: got ph=%0d r=%b want 4 1", cap[GT].ph, cap[GT + YT].r); end
    total++; if (first_done(0, 47) != 47) begin bad++; $display("FAIL dark_done_at: got %0d want 47", first_done(0, 47)); end
  endtask

  task automatic test_enable_drop();
    bit found = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clock);
      if (green && timer == TW'(10)) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL drop_wait: got timeout want green timer=10"); end
    enable = 1'b0;
    capture(40);
    total++; if (cnt(0, 36, 1) != YT || cnt(0, 36, 2) != RT) begin bad++; $display("FAIL drop_complete: got y=%0d r=%0d want %0d %0d", cnt(0, 36, 1), cnt(0, 36, 2), YT, RT); end
    total++; if (cap[37] !== samp_t'(0) || cap[39] !== samp_t'(0)) begin bad++; $display("FAIL drop_idle: got %h %h want 0", cap[37], cap[39]); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    enable = 1'b1;
    @(negedge clock);
    fault_sel = 2'd2; fault_arm = 1'b1;
    @(negedge clock);
    fault_arm = 1'b0; fault_sel = 2'd0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clock);
      if (red && timer == TW'(7)) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rstmid_wait: got timeout want red timer=7"); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (dut_now() !== samp_t'(0)) begin bad++; $display("FAIL rstmid_state: got %h want 0", dut_now()); end
    reset = 1'b0;
    capture(48);
    total++; if (cnt(0, 47, 1) != YT || cnt(0, 47, 4) != 0) begin bad++; $display("FAIL rstmid_pending: got y=%0d fa=%0d want %0d 0", cnt(0, 47, 1), cnt(0, 47, 4), YT); end
  endtask

  task automatic test_back_to_back();
    bit found = 1'b0;
    samp_t s0;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clock);
      if (cycle_done) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL b2b_wait: got timeout want cycle_done"); end
    fault_sel = 2'd1; fault_arm = 1'b1;
    @(negedge clock);
    fault_arm = 1'b0; fault_sel = 2'd0;
    s0 = dut_now();
    total++; if (s0.g !== 1'b1 || s0.fa !== 1'b0) begin bad++; $display("FAIL b2b_entry: got g=%b fa=%b want 1 0", s0.g, s0.fa); end
    capture(92);
    total++; if (cnt(0, 46, 1) != YT || cnt(0, 46, 4) != 0) begin bad++; $display("FAIL b2b_current: got y=%0d fa=%0d want %0d 0", cnt(0, 46, 1), cnt(0, 46, 4), YT); end
    total++; if (cnt(47, 91, 1) != 0 || cnt(47, 91, 4) != 45) begin bad++; $display("FAIL b2b_following: got y=%0d fa=%0d want 0 45", cnt(47, 91, 1), cnt(47, 91, 4)); end
    total++; if (first_done(47, 91) != 91) begin bad++; $display("FAIL b2b_done: got %0d want 91", first_done(47, 91)); end
  endtask

  task automatic test_random();
    samp_t exp_s;
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      exp_s = model_out(m_run, m_pos, m_fcur);
      total++;
      if (dut_now() !== exp_s) begin
        bad++; errs++;
        if (errs <= 10) $display("FAIL random_cycle %0d: got %h want %h", i, dut_now(), exp_s);
      end
      enable    = ($urandom_range(0, 9) != 0);
      fault_arm = ($urandom_range(0, 15) == 0);
      fault_sel = 2'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0; fault_arm = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_fault_skip();
    test_fault_stretch();
    test_fault_dark();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
